// File: rtl/tea_iter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tea_iter_sequencer
// Description : Iterative TEA engine. A single TEA cycle datapath (two
//               Feistel half-rounds) is reused ROUNDS times under a small
//               IDLE/RUN/DONE FSM. One job (64-bit block, 128-bit key,
//               direction) is taken per in_valid/in_ready transfer. The
//               result is held on outBlock64 until out_valid/out_ready
//               completes.
// Ports       : clk, rst (async, active high), ena (clock enable)
//               in_valid/in_ready, encrypt, inBlock64[63:0], key[127:0]
//               out_valid/out_ready, outBlock64[63:0], busy
//               abort (only when TEA_SEQ_ABORT_EN is defined)
// Config      : `define TEA_SEQ_ABORT_EN adds the abort input, which drops a
//               job in RUN or DONE and returns to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module tea_iter_sequencer #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         rst,
`ifdef TEA_SEQ_ABORT_EN
    input  logic         abort,
`endif
    input  logic         ena,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         encrypt,
    input  logic [63:0]  inBlock64,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  outBlock64,
    output logic         busy
);

    localparam int unsigned CW = $clog2(ROUNDS + 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [CW-1:0] c_last_round = CW'(ROUNDS - 1);
    localparam logic [CW-1:0] c_cnt_one    = CW'(1);
    // Decryption walks the key schedule backwards from DELTA*ROUNDS (mod 2^32).
    localparam logic [31:0]   c_dec_sum_init = 32'(DELTA * ROUNDS);

    logic [1:0]    r_state;
    logic [CW-1:0] r_round_cnt;
    logic [31:0]   r_sum;
    logic [31:0]   r_v0;
    logic [31:0]   r_v1;
    logic [127:0]  r_key;
    logic          r_encrypt;

    logic          w_abort;
    logic [31:0]   w_k0, w_k1, w_k2, w_k3;
    logic [31:0]   w_s;
    logic [31:0]   w_enc_v0, w_enc_v1;
    logic [31:0]   w_dec_v0, w_dec_v1;

`ifdef TEA_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_k0 = r_key[127:96];
    assign w_k1 = r_key[95:64];
    assign w_k2 = r_key[63:32];
    assign w_k3 = r_key[31:0];

    // Encrypt: the sum advances before use; v1 half-round sees the new v0.
    assign w_s      = r_sum + DELTA;
    assign w_enc_v0 = r_v0 + (((r_v1 << 4) + w_k0) ^ (r_v1 + w_s) ^ ((r_v1 >> 5) + w_k1));
    assign w_enc_v1 = r_v1 + (((w_enc_v0 << 4) + w_k2) ^ (w_enc_v0 + w_s) ^ ((w_enc_v0 >> 5) + w_k3));

    // Decrypt: undo the half-rounds in reverse order using the current sum.
    assign w_dec_v1 = r_v1 - (((r_v0 << 4) + w_k2) ^ (r_v0 + r_sum) ^ ((r_v0 >> 5) + w_k3));
    assign w_dec_v0 = r_v0 - (((w_dec_v1 << 4) + w_k0) ^ (w_dec_v1 + r_sum) ^ ((w_dec_v1 >> 5) + w_k1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_round_cnt <= '0;
            r_sum       <= '0;
            r_v0        <= '0;
            r_v1        <= '0;
            r_key       <= '0;
            r_encrypt   <= 1'b0;
        end else if (ena) begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_state     <= c_run;
                        r_v0        <= inBlock64[63:32];
                        r_v1        <= inBlock64[31:0];
                        r_key       <= key;
                        r_encrypt   <= encrypt;
                        r_round_cnt <= '0;
                        r_sum       <= encrypt ? 32'd0 : c_dec_sum_init;
                    end
                end
                c_run: begin
                    if (w_abort) begin
                        r_state <= c_idle;
                    end else begin
                        if (r_encrypt) begin
                            r_v0  <= w_enc_v0;
                            r_v1  <= w_enc_v1;
                            r_sum <= w_s;
                        end else begin
                            r_v0  <= w_dec_v0;
                            r_v1  <= w_dec_v1;
                            r_sum <= r_sum - DELTA;
                        end
                        // Counter stops at the last round so it never wraps.
                        if (r_round_cnt == c_last_round) begin
                            r_state <= c_done;
                        end else begin
                            r_round_cnt <= r_round_cnt + c_cnt_one;
                        end
                    end
                end
                c_done: begin
                    // Abort wins over a simultaneous hand-off.
                    if (w_abort || out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign in_ready   = (r_state == c_idle) && ena;
    assign out_valid  = (r_state == c_done);
    assign busy       = (r_state != c_idle);
    // Block registers only move in RUN/accept, so the result is stable in DONE.
    assign outBlock64 = {r_v0, r_v1};

endmodule
`default_nettype wire
